// File: rtl/execute_stage_if.sv
// Execute-stage bus: decoded instruction from ID, forwarding sources from
// MEM/WB, and the EX/MEM pipeline register outputs plus the front-end stall.
interface execute_stage_if #(parameter int DATA_W = 32);
  logic              id_exe_valid;
  logic [DATA_W-1:0] id_exe_rs1_data;
  logic [DATA_W-1:0] id_exe_rs2_data;
  logic [DATA_W-1:0] id_exe_imm;
  logic [4:0]        id_exe_rs1_add;
  logic [4:0]        id_exe_rs2_add;
  logic [4:0]        id_exe_reg_wr_add;
  logic [3:0]        id_exe_alu_op;
  logic              id_exe_alu_src;
  logic [2:0]        id_exe_ctrl_sgs;
  logic [DATA_W-1:0] mem_exe_reslt_data;
  logic [DATA_W-1:0] wb_exe_reg_wr_data;
  logic [4:0]        wb_exe_reg_wr_add;
  logic              wb_exe_reg_wr_en;
  logic [DATA_W-1:0] exe_mem_reslt_data_out;
  logic [DATA_W-1:0] exe_mem_wr_data;
  logic [4:0]        exe_mem_reg_wr_add;
  logic [2:0]        exe_mem_ctrl_sgs;
  logic              exe_hctrl_stall;

  modport master (
    output id_exe_valid, id_exe_rs1_data, id_exe_rs2_data, id_exe_imm,
           id_exe_rs1_add, id_exe_rs2_add, id_exe_reg_wr_add, id_exe_alu_op,
           id_exe_alu_src, id_exe_ctrl_sgs, mem_exe_reslt_data,
           wb_exe_reg_wr_data, wb_exe_reg_wr_add, wb_exe_reg_wr_en,
    input  exe_mem_reslt_data_out, exe_mem_wr_data, exe_mem_reg_wr_add,
           exe_mem_ctrl_sgs, exe_hctrl_stall
  );

  modport slave (
    input  id_exe_valid, id_exe_rs1_data, id_exe_rs2_data, id_exe_imm,
           id_exe_rs1_add, id_exe_rs2_add, id_exe_reg_wr_add, id_exe_alu_op,
           id_exe_alu_src, id_exe_ctrl_sgs, mem_exe_reslt_data,
           wb_exe_reg_wr_data, wb_exe_reg_wr_add, wb_exe_reg_wr_en,
    output exe_mem_reslt_data_out, exe_mem_wr_data, exe_mem_reg_wr_add,
           exe_mem_ctrl_sgs, exe_hctrl_stall
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, 32-step shift-add
// multiplier that stalls the front end, and the EX/MEM pipeline register.
module execute_stage #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave bus
);
  localparam int CNT_W = $clog2(MUL_CYCLES);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR   = 4'd3,
    OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA  = 4'd7,
    OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10, OP_PASSB = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  mul_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc, mcand, mplier;

  logic [DATA_W-1:0] result_q, wr_data_q;
  logic [4:0]        wr_add_q;
  logic [2:0]        ctrl_q;

  logic [DATA_W-1:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_result;
  logic [4:0]        shamt;
  logic              is_mul, stall;

  // EX/MEM is the fresher source, so it is tested before WB; r0 never forwards.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rs1_fwd = bus.id_exe_rs1_data;
    if (bus.id_exe_rs1_add != 5'd0) begin
      if (ctrl_q[2] && wr_add_q == bus.id_exe_rs1_add)
        rs1_fwd = bus.mem_exe_reslt_data;
      else if (bus.wb_exe_reg_wr_en && bus.wb_exe_reg_wr_add == bus.id_exe_rs1_add)
        rs1_fwd = bus.wb_exe_reg_wr_data;
    end
    rs2_fwd = bus.id_exe_rs2_data;
    if (bus.id_exe_rs2_add != 5'd0) begin
      if (ctrl_q[2] && wr_add_q == bus.id_exe_rs2_add)
        rs2_fwd = bus.mem_exe_reslt_data;
      else if (bus.wb_exe_reg_wr_en && bus.wb_exe_reg_wr_add == bus.id_exe_rs2_add)
        rs2_fwd = bus.wb_exe_reg_wr_data;
    end
  end

  assign op_a   = rs1_fwd;
  assign op_b   = bus.id_exe_alu_src ? bus.id_exe_imm : rs2_fwd;
  assign shamt  = op_b[4:0];
  assign is_mul = bus.id_exe_valid && (bus.id_exe_alu_op == OP_MUL);
  assign stall  = is_mul && (state != DONE);

  always_comb begin
    alu_result = '0;
    case (bus.id_exe_alu_op)
      OP_ADD:   alu_result = op_a + op_b;
      OP_SUB:   alu_result = op_a - op_b;
      OP_AND:   alu_result = op_a & op_b;
      OP_OR:    alu_result = op_a | op_b;
      OP_XOR:   alu_result = op_a ^ op_b;
      OP_SLL:   alu_result = op_a << shamt;
      OP_SRL:   alu_result = op_a >> shamt;
      OP_SRA:   alu_result = $signed(op_a) >>> shamt;
      OP_SLT:   alu_result = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:  alu_result = {{(DATA_W-1){1'b0}}, op_a < op_b};
      OP_MUL:   alu_result = acc;
      OP_PASSB: alu_result = op_b;
      default:  alu_result = '0;
    endcase
  end

  // Operands are captured on entry to BUSY so forwarding changes later are ignored.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE: if (is_mul) begin
          mcand  <= op_a;
          mplier <= op_b;
          acc    <= '0;
          cnt    <= '0;
          state  <= BUSY;
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(MUL_CYCLES - 1)) state <= DONE;
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q  <= '0;
      wr_data_q <= '0;
      wr_add_q  <= '0;
      ctrl_q    <= '0;
    end else if (stall || !bus.id_exe_valid) begin
      result_q  <= '0;
      wr_data_q <= '0;
      wr_add_q  <= '0;
      ctrl_q    <= '0;
    end else begin
      result_q  <= alu_result;
      wr_data_q <= rs2_fwd;
      wr_add_q  <= bus.id_exe_reg_wr_add;
      ctrl_q    <= bus.id_exe_ctrl_sgs;
    end
  end

  assign bus.exe_mem_reslt_data_out = result_q;
  assign bus.exe_mem_wr_data        = wr_data_q;
  assign bus.exe_mem_reg_wr_add     = wr_add_q;
  assign bus.exe_mem_ctrl_sgs       = ctrl_q;
  assign bus.exe_hctrl_stall        = stall;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: forwarding, ALU corner cases, multiplier
// latency/stall and reset abort, with hand-computed expected values.
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  execute_stage_if #(.DATA_W(32)) bus ();

  execute_stage #(.DATA_W(32), .MUL_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3,
                         XOR_ = 4'd4, SLL = 4'd5, SRL = 4'd6, SRA = 4'd7,
                         SLT = 4'd8, SLTU = 4'd9, MUL = 4'd10, PASSB = 4'd11;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] imm,
                       input logic src, input logic [4:0] rd, input logic [2:0] ctrl);
    bus.id_exe_valid      = 1'b1;
    bus.id_exe_alu_op     = op;
    bus.id_exe_rs1_add    = a1;
    bus.id_exe_rs1_data   = d1;
    bus.id_exe_rs2_add    = a2;
    bus.id_exe_rs2_data   = d2;
    bus.id_exe_imm        = imm;
    bus.id_exe_alu_src    = src;
    bus.id_exe_reg_wr_add = rd;
    bus.id_exe_ctrl_sgs   = ctrl;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] add, input logic [31:0] data);
    bus.wb_exe_reg_wr_en   = en;
    bus.wb_exe_reg_wr_add  = add;
    bus.wb_exe_reg_wr_data = data;
  endtask

  // Runs the stall phase of a MUL already on the inputs; returns stalled cycles and bubble violations.
  task automatic run_mul(input bit poke_wb, output int n, output int bad);
    n = 0;
    bad = 0;
    while (bus.exe_hctrl_stall && n < 40) begin
      if (poke_wb && n == 1) set_wb(1'b1, 5'd14, 32'h0);
      tick();
      n++;
      if (bus.exe_mem_ctrl_sgs !== 3'b000 || bus.exe_mem_reslt_data_out !== 32'h0) bad++;
    end
  endtask

  initial begin
    int n, bad;
    bus.id_exe_valid = 1'b0;
    issue(ADD, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 3'b000);
    bus.id_exe_valid = 1'b0;
    bus.mem_exe_reslt_data = 32'h0;
    set_wb(1'b0, 5'd0, 32'h0);

    // Reset held
    tick(); tick();
    check("rst_result", bus.exe_mem_reslt_data_out, 32'h0);
    check("rst_wr_data", bus.exe_mem_wr_data, 32'h0);
    check("rst_wr_add", {27'd0, bus.exe_mem_reg_wr_add}, 32'h0);
    check("rst_ctrl", {29'd0, bus.exe_mem_ctrl_sgs}, 32'h0);
    check("rst_stall", {31'd0, bus.exe_hctrl_stall}, 32'h0);
    rst = 1'b1;

    // ADD r3 = 5 + 7
    issue(ADD, 5'd6, 32'd5, 5'd7, 32'd7, 32'h0, 1'b0, 5'd3, 3'b100);
    tick();
    check("add_result", bus.exe_mem_reslt_data_out, 32'd12);
    check("add_ctrl", {29'd0, bus.exe_mem_ctrl_sgs}, 32'h4);
    check("add_wr_add", {27'd0, bus.exe_mem_reg_wr_add}, 32'd3);

    // ADD r1 = 4 + 6, then SUB r2 = r1 - 3 via EX/MEM forwarding
    issue(ADD, 5'd8, 32'd4, 5'd0, 32'h0, 32'd6, 1'b1, 5'd1, 3'b100);
    tick();
    check("add_r1", bus.exe_mem_reslt_data_out, 32'd10);
    bus.mem_exe_reslt_data = 32'd10;
    issue(SUB, 5'd1, 32'd999, 5'd0, 32'h0, 32'd3, 1'b1, 5'd2, 3'b100);
    tick();
    check("fwd_mem_sub", bus.exe_mem_reslt_data_out, 32'd7);

    // r9 = r1 (from WB) + r2 (from EX/MEM)
    bus.mem_exe_reslt_data = 32'd7;
    set_wb(1'b1, 5'd1, 32'd10);
    issue(ADD, 5'd1, 32'h0, 5'd2, 32'h0, 32'h0, 1'b0, 5'd9, 3'b100);
    tick();
    check("fwd_wb_and_mem", bus.exe_mem_reslt_data_out, 32'd17);
    check("fwd_store_data", bus.exe_mem_wr_data, 32'd7);

    // Both EX/MEM and WB match r9: EX/MEM wins
    bus.mem_exe_reslt_data = 32'd17;
    set_wb(1'b1, 5'd9, 32'h55);
    issue(XOR_, 5'd9, 32'h0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd10, 3'b100);
    tick();
    check("fwd_priority", bus.exe_mem_reslt_data_out, 32'd17);

    // Writes to r0 are never forwarded
    issue(ADD, 5'd0, 32'h0, 5'd0, 32'h0, 32'h77, 1'b1, 5'd0, 3'b100);
    tick();
    check("r0_dest_result", bus.exe_mem_reslt_data_out, 32'h77);
    bus.mem_exe_reslt_data = 32'h77;
    set_wb(1'b1, 5'd0, 32'h66);
    issue(ADD, 5'd0, 32'd5, 5'd0, 32'h0, 32'h0, 1'b0, 5'd11, 3'b100);
    tick();
    check("r0_no_fwd", bus.exe_mem_reslt_data_out, 32'd5);
    check("r0_no_fwd_wdata", bus.exe_mem_wr_data, 32'h0);

    // Load to r4, then OR r5 = r4 | 0 with load data forwarded
    set_wb(1'b0, 5'd0, 32'h0);
    issue(ADD, 5'd12, 32'h200, 5'd0, 32'h0, 32'd4, 1'b1, 5'd4, 3'b101);
    tick();
    check("load_addr", bus.exe_mem_reslt_data_out, 32'h204);
    check("load_ctrl", {29'd0, bus.exe_mem_ctrl_sgs}, 32'h5);
    bus.mem_exe_reslt_data = 32'hDEADBEEF;
    issue(OR_, 5'd4, 32'h0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd5, 3'b100);
    tick();
    check("load_use", bus.exe_mem_reslt_data_out, 32'hDEADBEEF);

    // Store with rs2 forwarded from WB
    set_wb(1'b1, 5'd6, 32'h1234);
    issue(ADD, 5'd13, 32'h100, 5'd6, 32'h0, 32'd8, 1'b1, 5'd0, 3'b010);
    tick();
    check("store_addr", bus.exe_mem_reslt_data_out, 32'h108);
    check("store_data", bus.exe_mem_wr_data, 32'h1234);
    check("store_ctrl", {29'd0, bus.exe_mem_ctrl_sgs}, 32'h2);
    set_wb(1'b0, 5'd0, 32'h0);

    // ALU corner cases
    issue(SRA, 5'd20, 32'h80000000, 5'd0, 32'h0, 32'd4, 1'b1, 5'd31, 3'b100);
    tick(); check("sra", bus.exe_mem_reslt_data_out, 32'hF8000000);
    issue(SLT, 5'd20, 32'hFFFFFFFF, 5'd0, 32'h0, 32'd1, 1'b1, 5'd31, 3'b100);
    tick(); check("slt", bus.exe_mem_reslt_data_out, 32'd1);
    issue(SLTU, 5'd20, 32'hFFFFFFFF, 5'd0, 32'h0, 32'd1, 1'b1, 5'd31, 3'b100);
    tick(); check("sltu", bus.exe_mem_reslt_data_out, 32'd0);
    issue(ADD, 5'd20, 32'hFFFFFFFF, 5'd0, 32'h0, 32'd1, 1'b1, 5'd31, 3'b100);
    tick(); check("add_wrap", bus.exe_mem_reslt_data_out, 32'd0);
    issue(SUB, 5'd20, 32'h0, 5'd0, 32'h0, 32'd1, 1'b1, 5'd31, 3'b100);
    tick(); check("sub_wrap", bus.exe_mem_reslt_data_out, 32'hFFFFFFFF);
    issue(SLL, 5'd20, 32'h1, 5'd0, 32'h0, 32'h25, 1'b1, 5'd31, 3'b100);
    tick(); check("sll_shamt5", bus.exe_mem_reslt_data_out, 32'h20);
    issue(SRL, 5'd20, 32'h80000000, 5'd0, 32'h0, 32'd4, 1'b1, 5'd31, 3'b100);
    tick(); check("srl", bus.exe_mem_reslt_data_out, 32'h08000000);
    issue(AND_, 5'd20, 32'hF0F0, 5'd21, 32'h0FF0, 32'h0, 1'b0, 5'd31, 3'b100);
    tick(); check("and", bus.exe_mem_reslt_data_out, 32'h00F0);
    issue(PASSB, 5'd20, 32'h1, 5'd0, 32'h0, 32'hABCD, 1'b1, 5'd31, 3'b100);
    tick(); check("passb", bus.exe_mem_reslt_data_out, 32'hABCD);
    issue(4'd13, 5'd20, 32'h1, 5'd0, 32'h0, 32'hABCD, 1'b1, 5'd31, 3'b100);
    tick(); check("op13_zero", bus.exe_mem_reslt_data_out, 32'h0);

    // Invalid slot loads a bubble
    bus.id_exe_valid = 1'b0;
    tick();
    check("bubble_ctrl", {29'd0, bus.exe_mem_ctrl_sgs}, 32'h0);
    check("bubble_result", bus.exe_mem_reslt_data_out, 32'h0);

    // MUL 0xFFFFFFFF * 3, WB forwarding for rs1 changes mid-multiply
    issue(MUL, 5'd14, 32'hFFFFFFFF, 5'd0, 32'h0, 32'd3, 1'b1, 5'd7, 3'b100);
    #1;
    check("mul_stall_first", {31'd0, bus.exe_hctrl_stall}, 32'h1);
    run_mul(1'b1, n, bad);
    check("mul_stall_cycles", n, 32'd33);
    check("mul_bubbles", bad, 32'd0);
    tick();
    check("mul_total_cycles", n + 1, 32'd34);
    check("mul_product", bus.exe_mem_reslt_data_out, 32'hFFFFFFFD);
    check("mul_ctrl", {29'd0, bus.exe_mem_ctrl_sgs}, 32'h4);
    check("mul_wr_add", {27'd0, bus.exe_mem_reg_wr_add}, 32'd7);
    bus.id_exe_valid = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);

    // Second MUL aborted by reset in its 10th cycle
    issue(MUL, 5'd14, 32'd6, 5'd0, 32'h0, 32'd7, 1'b1, 5'd8, 3'b100);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b0;
    bus.id_exe_valid = 1'b0;
    #1;
    check("abort_result", bus.exe_mem_reslt_data_out, 32'h0);
    check("abort_stall", {31'd0, bus.exe_hctrl_stall}, 32'h0);
    tick();
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.exe_mem_ctrl_sgs !== 3'b000) bad++;
    end
    check("abort_no_issue", bad, 32'd0);

    // A fresh MUL must take the full latency, so the FSM restarted from IDLE
    issue(MUL, 5'd14, 32'd6, 5'd0, 32'h0, 32'd7, 1'b1, 5'd8, 3'b100);
    #1;
    run_mul(1'b0, n, bad);
    check("mul2_stall_cycles", n, 32'd33);
    tick();
    check("mul2_product", bus.exe_mem_reslt_data_out, 32'd42);
    check("mul2_wr_add", {27'd0, bus.exe_mem_reg_wr_add}, 32'd8);
    bus.id_exe_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
